// File: rtl/coherence_bus_arbiter_pkg.sv
// Shared types for the MSI snoop-bus arbiter: bus operations, arbiter states,
// data-select encodings and the per-CPU operation priority helper.
package coherence_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_RD,
        OP_WR,
        OP_INV,
        OP_EVICT
    } bus_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNOOP,
        ST_XFER,
        ST_MEM,
        ST_DONE
    } arb_state_t;

    localparam logic [1:0] DSEL_MEM  = 2'b00;
    localparam logic [1:0] DSEL_CPU  = 2'b01;
    localparam logic [1:0] DSEL_IDLE = 2'b11;

    // A CPU may raise several requests at once; a dirty evict must leave
    // before the line is refilled, and a write miss subsumes a read miss.
    function automatic bus_op_t pick_op(input logic rd, input logic wr,
                                        input logic inv, input logic ev);
        bus_op_t op;
        op = OP_NONE;
        if (ev)
            op = OP_EVICT;
        else if (wr)
            op = OP_WR;
        else if (rd)
            op = OP_RD;
        else if (inv)
            op = OP_INV;
        return op;
    endfunction

endpackage

// File: rtl/coherence_bus_arbiter_rr_pick2.sv
// Two-way round-robin picker: the requester at ptr wins, otherwise the other one.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    logic other;

    assign other = ~ptr;

    // Prefer the CPU the pointer names, fall back to the other CPU.
    always_comb begin
        gnt = 2'b00;
        if (req[ptr])
            gnt[ptr] = 1'b1;
        else if (req[other])
            gnt[other] = 1'b1;
    end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Snoop-bus / unified-memory arbiter for two MSI data caches.
// Optional performance counters are enabled with `define COH_BUS_PERF_EN.
module coherence_bus_arbiter
    import coherence_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 16,
    parameter int TMO_CYC = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             rd_miss,
    input  logic [1:0]             wr_miss,
    input  logic [1:0]             inval_req,
    input  logic [1:0]             evict_req,
    input  logic [1:0][ADDR_W-1:0] bico,
    input  logic [1:0]             search_found,
    input  logic [1:0][DATA_W-1:0] snoop_data,
    input  logic                   u_rdy,
    output logic [1:0]             grant,
    output logic [1:0]             cpu_search,
    output logic [ADDR_W-1:0]      boci,
    output logic [DATA_W-1:0]      bus_data,
    output logic [1:0][1:0]        cpu_datasel,
    output logic [1:0]             dmem_perm,
    output logic [1:0]             inval_out,
    output logic                   busy,
    output logic                   tmo_err
`ifdef COH_BUS_PERF_EN
    ,
    output logic [15:0]            perf_txn,
    output logic [15:0]            perf_c2c
`endif
);

    localparam int              CNT_W    = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

    arb_state_t       state;
    arb_state_t       state_n;
    bus_op_t          cur_op;
    bus_op_t          win_op;
    logic             cur_cpu;
    logic             other_cpu;
    logic             win_cpu;
    logic             rr_ptr;
    logic [1:0]       req_any;
    logic [1:0]       pick_gnt;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;

    assign req_any   = rd_miss | wr_miss | inval_req | evict_req;
    assign win_cpu   = pick_gnt[1];
    assign win_op    = pick_op(rd_miss[win_cpu], wr_miss[win_cpu],
                               inval_req[win_cpu], evict_req[win_cpu]);
    assign other_cpu = ~cur_cpu;
    assign tmo_hit   = (tmo_cnt == TMO_LAST) && !u_rdy;

    rr_pick2 u_pick (
        .req (req_any),
        .ptr (rr_ptr),
        .gnt (pick_gnt)
    );

    // State register; an asynchronous reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    // Next-state decode and the bus strobes, all driven from the current state.
    always_comb begin
        state_n     = state;
        grant       = 2'b00;
        cpu_search  = 2'b00;
        inval_out   = 2'b00;
        dmem_perm   = 2'b00;
        cpu_datasel = {DSEL_IDLE, DSEL_IDLE};
        busy        = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (|pick_gnt)
                    state_n = (win_op == OP_EVICT) ? ST_MEM : ST_SNOOP;
            end
            ST_SNOOP: begin
                cpu_search[other_cpu] = 1'b1;
                if (cur_op == OP_INV || cur_op == OP_WR)
                    inval_out[other_cpu] = 1'b1;
                if (cur_op == OP_INV)
                    state_n = ST_DONE;
                else if (search_found[other_cpu])
                    state_n = ST_XFER;
                else
                    state_n = ST_MEM;
            end
            ST_XFER: begin
                cpu_datasel[cur_cpu] = DSEL_CPU;
                state_n = ST_DONE;
            end
            ST_MEM: begin
                dmem_perm[cur_cpu]   = 1'b1;
                cpu_datasel[cur_cpu] = (cur_op == OP_EVICT) ? DSEL_IDLE : DSEL_MEM;
                if (u_rdy || tmo_hit)
                    state_n = ST_DONE;
            end
            ST_DONE: begin
                grant[cur_cpu] = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Transaction context: winner, address, snooped word, fairness pointer and memory timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_cpu  <= 1'b0;
            cur_op   <= OP_NONE;
            boci     <= '0;
            bus_data <= '0;
            rr_ptr   <= 1'b0;
            tmo_cnt  <= '0;
            tmo_err  <= 1'b0;
        end else begin
            if (state != ST_MEM)
                tmo_cnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (|pick_gnt) begin
                        cur_cpu <= win_cpu;
                        cur_op  <= win_op;
                        boci    <= bico[win_cpu];
                    end
                end
                ST_SNOOP: begin
                    if (cur_op != OP_INV && search_found[other_cpu])
                        bus_data <= snoop_data[other_cpu];
                end
                ST_MEM: begin
                    if (!u_rdy) begin
                        if (tmo_cnt == TMO_LAST)
                            tmo_err <= 1'b1;
                        else
                            tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_DONE: rr_ptr <= other_cpu;
                default: ;
            endcase
        end
    end

`ifdef COH_BUS_PERF_EN
    // Saturating counts of completed transactions and cache-to-cache transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_txn <= '0;
            perf_c2c <= '0;
        end else begin
            if (state == ST_DONE && perf_txn != 16'hFFFF)
                perf_txn <= perf_txn + 16'd1;
            if (state == ST_XFER && perf_c2c != 16'hFFFF)
                perf_c2c <= perf_c2c + 16'd1;
        end
    end
`endif

endmodule
